// File: rtl/fir_param.sv
// Streaming FIR filter configured over AXI-Lite, one multiply-accumulate per tap per sample.
// Define FIR_SATURATE_EN for a wide accumulator with signed saturation; otherwise results wrap.
module fir_param #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTAP_MAX    = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    localparam int DW = pDATA_WIDTH;
    localparam int KW = $clog2(pTAP_MAX + 1);
    localparam int IW = (pTAP_MAX > 1) ? $clog2(pTAP_MAX) : 1;
`ifdef FIR_SATURATE_EN
    localparam int AW = 2 * DW + $clog2(pTAP_MAX);
    localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - 1;
`else
    localparam int AW = DW;
`endif
    localparam logic [pADDR_WIDTH-1:0] A_CTRL    = '0;
    localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] A_TAPN    = pADDR_WIDTH'('h14);
    localparam logic [pADDR_WIDTH-1:0] A_TAP0    = pADDR_WIDTH'('h20);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(32'h20 + 4 * pTAP_MAX);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_WAIT_IN, S_MAC, S_OUT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  awready_q, awready_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  ap_done_q, ap_done_d, tlast_err_q, tlast_err_d;
    logic [DW-1:0]         data_length_q, data_length_d, cnt_q, cnt_d;
    logic [KW-1:0]         tap_num_q, tap_num_d;
    logic [IW-1:0]         k_q, k_d;
    logic signed [DW-1:0]  taps_q [pTAP_MAX];
    logic signed [DW-1:0]  taps_d [pTAP_MAX];
    logic signed [DW-1:0]  hist_q [pTAP_MAX];
    logic signed [DW-1:0]  hist_d [pTAP_MAX];
    logic signed [AW-1:0]  acc_q, acc_d, acc_sum;
    logic [DW-1:0]         sm_tdata_q, sm_tdata_d;
    logic                  sm_tlast_q, sm_tlast_d;

    logic                  wr_en, rd_en, start, ap_idle, mac_last, w_tap_hit, r_tap_hit;
    logic [IW-1:0]         w_idx, r_idx;
    logic signed [2*DW-1:0] prod;
    logic [DW-1:0]         result, rd_mux;

    assign wr_en     = awready_q && awvalid && wvalid;
    assign rd_en     = arready_q && arvalid;
    assign ap_idle   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start     = wr_en && (awaddr == A_CTRL) && wdata[0] && (state_q == S_IDLE);
    assign w_tap_hit = (awaddr >= A_TAP0) && (awaddr < A_TAP_END) && (awaddr[1:0] == 2'b00);
    assign r_tap_hit = (araddr >= A_TAP0) && (araddr < A_TAP_END) && (araddr[1:0] == 2'b00);
    assign w_idx     = IW'((awaddr - A_TAP0) >> 2);
    assign r_idx     = IW'((araddr - A_TAP0) >> 2);
    // k counts taps already applied; guard with >= so a zero tap_num still terminates
    assign mac_last  = (KW'(k_q) + 1'b1) >= tap_num_q;
    assign prod      = taps_q[k_q] * hist_q[k_q];
    assign acc_sum   = acc_q + AW'(prod);

    always_comb begin
`ifdef FIR_SATURATE_EN
        if (acc_sum > SAT_MAX)      result = SAT_MAX[DW-1:0];
        else if (acc_sum < SAT_MIN) result = SAT_MIN[DW-1:0];
        else                        result = acc_sum[DW-1:0];
`else
        result = acc_sum;
`endif
    end

    always_comb begin
        rd_mux = '0;
        if (araddr == A_CTRL)      rd_mux = DW'({tlast_err_q, ap_idle, ap_done_q, 1'b0});
        else if (araddr == A_LEN)  rd_mux = data_length_q;
        else if (araddr == A_TAPN) rd_mux = DW'(tap_num_q);
        else if (r_tap_hit)        rd_mux = taps_q[r_idx];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CLR;
            S_CLR:     state_d = (data_length_q == '0) ? S_DONE : S_WAIT_IN;
            S_WAIT_IN: if (ss_tvalid) state_d = S_MAC;
            S_MAC:     if (mac_last) state_d = S_OUT;
            S_OUT:     if (sm_tready) state_d = sm_tlast_q ? S_DONE : S_WAIT_IN;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        awready_d     = awvalid && wvalid && !awready_q;
        arready_d     = arvalid && !arready_q && !rvalid_q;
        rvalid_d      = rvalid_q ? !rready : rd_en;
        rdata_d       = rd_en ? rd_mux : rdata_q;
        ap_done_d     = ap_done_q;
        tlast_err_d   = tlast_err_q;
        data_length_d = data_length_q;
        tap_num_d     = tap_num_q;
        taps_d        = taps_q;
        hist_d        = hist_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        acc_d         = acc_q;
        sm_tdata_d    = sm_tdata_q;
        sm_tlast_d    = sm_tlast_q;
        // clear-on-read comes first so a same-cycle set from DONE wins
        if (rd_en && (araddr == A_CTRL)) ap_done_d = 1'b0;
        if (state_q == S_DONE)           ap_done_d = 1'b1;
        if (start)                       tlast_err_d = 1'b0;
        if (wr_en && ap_idle) begin
            if (awaddr == A_LEN)  data_length_d = wdata;
            if (awaddr == A_TAPN) tap_num_d = (wdata == '0) ? KW'(1) :
                                              (wdata > DW'(pTAP_MAX)) ? KW'(pTAP_MAX) : KW'(wdata);
            if (w_tap_hit)        taps_d[w_idx] = wdata;
        end
        case (state_q)
            S_CLR: begin
                for (int i = 0; i < pTAP_MAX; i++) hist_d[i] = '0;
                cnt_d = '0;
            end
            S_WAIT_IN: if (ss_tvalid) begin
                hist_d[0] = ss_tdata;
                for (int i = 1; i < pTAP_MAX; i++) hist_d[i] = hist_q[i-1];
                cnt_d = cnt_q + 1'b1;
                if (ss_tlast && ((cnt_q + 1'b1) != data_length_q)) tlast_err_d = 1'b1;
                k_d   = '0;
                acc_d = '0;
            end
            S_MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 1'b1;
                if (mac_last) begin
                    sm_tdata_d = result;
                    sm_tlast_d = (cnt_q == data_length_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q       <= S_IDLE;
            awready_q     <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            ap_done_q     <= 1'b0;
            tlast_err_q   <= 1'b0;
            data_length_q <= '0;
            tap_num_q     <= '0;
            cnt_q         <= '0;
            k_q           <= '0;
            acc_q         <= '0;
            sm_tdata_q    <= '0;
            sm_tlast_q    <= 1'b0;
            for (int i = 0; i < pTAP_MAX; i++) begin
                taps_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            awready_q     <= awready_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            ap_done_q     <= ap_done_d;
            tlast_err_q   <= tlast_err_d;
            data_length_q <= data_length_d;
            tap_num_q     <= tap_num_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            acc_q         <= acc_d;
            sm_tdata_q    <= sm_tdata_d;
            sm_tlast_q    <= sm_tlast_d;
            taps_q        <= taps_d;
            hist_q        <= hist_d;
        end
    end

    always_comb begin
        ss_tready = (state_q == S_WAIT_IN);
        sm_tvalid = (state_q == S_OUT);
        sm_tlast  = sm_tlast_q && (state_q == S_OUT);
    end

    assign awready  = awready_q;
    assign wready   = awready_q;
    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign sm_tdata = sm_tdata_q;
endmodule

// File: tb/tb_fir_param.sv
// Scoreboard bench for fir_param: stream stimulus pushes reference outputs, a monitor pops and compares.
module tb_fir_param;
    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] ss_tdata, sm_tdata;

    fir_param dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          last_q[$];
    int          tap_m[16];
    int          tn_m;
    int          xs[$];
    int          samp[64];
    int          frame_out = 0;
    bit          bp_en = 0, stall_arm = 0, abort = 0;
    int          gold[11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    function automatic void timeout_fail(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endfunction

    // y[n] = sum over the active taps of tap[k]*x[n-k], exact, then wrapped or saturated
    function automatic logic [31:0] model_y(int n);
        logic signed [127:0] s = '0;
        logic signed [127:0] smax = 128'sh7FFFFFFF;
        logic signed [127:0] smin = -128'sh80000000;
        for (int k = 0; k < tn_m; k++)
            if (n - k >= 0) s += 128'(tap_m[k]) * 128'(xs[n-k]);
`ifdef FIR_SATURATE_EN
        if (s > smax) s = smax;
        if (s < smin) s = smin;
`endif
        return s[31:0];
    endfunction

    task automatic axi_write(input int a, input int d);
        int t = 0;
        @(posedge axis_clk); #1;
        awvalid = 1; wvalid = 1; awaddr = 12'(a); wdata = d;
        do begin @(negedge axis_clk); t++; end while (!(awready && wready) && t < 50);
        if (t >= 50) timeout_fail("awready/wready");
        @(posedge axis_clk); #1;
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input int a, output logic [31:0] d);
        int t = 0;
        d = '0;
        @(posedge axis_clk); #1;
        arvalid = 1; araddr = 12'(a);
        do begin @(negedge axis_clk); t++; end while (!arready && t < 50);
        if (t >= 50) timeout_fail("arready");
        @(posedge axis_clk); #1;
        arvalid = 0; rready = 1; t = 0;
        do begin @(negedge axis_clk); t++; end while (!rvalid && t < 50);
        if (t >= 50) timeout_fail("rvalid");
        d = rdata;
        @(posedge axis_clk); #1;
        rready = 0;
    endtask

    task automatic setup_frame(input int tn_raw, input int len);
        axi_write('h14, tn_raw);
        for (int k = 0; k < 16; k++) axi_write('h20 + 4 * k, tap_m[k]);
        axi_write('h10, len);
        tn_m = (tn_raw <= 0) ? 1 : ((tn_raw > 16) ? 16 : tn_raw);
        frame_out = 0;
        axi_write('h00, 1);
    endtask

    task automatic drive_frame(input int len, input int tlast_at);
        int t;
        xs.delete();
        @(posedge axis_clk); #1;
        for (int i = 0; i < len; i++) begin
            if (abort) break;
            ss_tvalid = 1; ss_tdata = samp[i]; ss_tlast = (i + 1 == tlast_at);
            t = 0;
            do begin @(negedge axis_clk); t++; end while (!ss_tready && !abort && t < 2000);
            if (abort) break;
            if (t >= 2000) begin timeout_fail("ss_tready"); break; end
            xs.push_back(samp[i]);
            exp_q.push_back(model_y(i));
            last_q.push_back(i + 1 == len);
            @(posedge axis_clk); #1;
        end
        ss_tvalid = 0; ss_tlast = 0;
    endtask

    task automatic finish_frame(input int err);
        int t = 0;
        logic [31:0] d;
        while (exp_q.size() != 0 && t < 3000) begin @(negedge axis_clk); t++; end
        if (exp_q.size() != 0) timeout_fail("output drain");
        repeat (3) @(posedge axis_clk);
        axi_read('h00, d);
        check("ctrl after frame", d, 32'(6 + 8 * err));
    endtask

    task automatic load_gold();
        for (int k = 0; k < 16; k++) tap_m[k] = (k < 11) ? gold[k] : 0;
    endtask

    task automatic check_quiet(string tag);
        check({tag, " awready"}, 32'(awready), 0);
        check({tag, " arready"}, 32'(arready), 0);
        check({tag, " rvalid"}, 32'(rvalid), 0);
        check({tag, " rdata"}, rdata, 0);
        check({tag, " ss_tready"}, 32'(ss_tready), 0);
        check({tag, " sm_tvalid"}, 32'(sm_tvalid), 0);
        check({tag, " sm_tlast"}, 32'(sm_tlast), 0);
        check({tag, " sm_tdata"}, sm_tdata, 0);
    endtask

    // monitor: compares every accepted output beat with the head of the scoreboard
    initial forever begin
        @(negedge axis_clk);
        if (!axis_rst && sm_tvalid && sm_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected output: got %h, expected no beat", sm_tdata);
            end else begin
                check("sm_tdata", sm_tdata, exp_q.pop_front());
                check("sm_tlast", 32'(sm_tlast), 32'(last_q.pop_front()));
            end
            frame_out++;
        end
    end

    // sink: drives sm_tready, with an optional 5-cycle stall on the third output
    initial begin
        logic [31:0] held;
        sm_tready = 1'b0;
        forever begin
            @(posedge axis_clk); #1;
            if (stall_arm && sm_tvalid && frame_out == 2) begin
                held = sm_tdata; sm_tready = 0; stall_arm = 0;
                repeat (5) begin
                    @(negedge axis_clk);
                    check("stall sm_tvalid", 32'(sm_tvalid), 1);
                    check("stall sm_tdata", sm_tdata, held);
                    check("stall ss_tready", 32'(ss_tready), 0);
                    @(posedge axis_clk); #1;
                end
            end
            sm_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        axis_rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check_quiet("reset");
        @(posedge axis_clk); #1;
        axis_rst = 0;
        axi_read('h00, d); check("ctrl after reset", d, 4);
        axi_read('h14, d); check("tap_num after reset", d, 0);
        axi_read('h20, d); check("tap0 after reset", d, 0);
        axi_write('h18, 32'h1234_5678);
        axi_read('h18, d); check("unmapped read", d, 0);

        // impulse response reproduces the taps
        load_gold();
        for (int i = 0; i < 11; i++) samp[i] = (i == 0) ? 1 : 0;
        setup_frame(11, 11);
        drive_frame(11, 11);
        finish_frame(0);
        axi_read('h00, d); check("ctrl done cleared", d, 4);

        // full-scale tap times 2: wraps or saturates
        for (int k = 0; k < 16; k++) tap_m[k] = 0;
        tap_m[0] = 32'h7FFF_FFFF; samp[0] = 2;
        setup_frame(1, 1);
        drive_frame(1, 1);
        finish_frame(0);

        // backpressure stall during output 3
        for (int k = 0; k < 16; k++) tap_m[k] = int'($urandom_range(0, 200)) - 100;
        for (int i = 0; i < 8; i++) samp[i] = int'($urandom_range(0, 2000)) - 1000;
        stall_arm = 1;
        setup_frame(5, 8);
        drive_frame(8, 8);
        finish_frame(0);
        check("stall happened", 32'(stall_arm), 0);

        // empty frame completes with no stream traffic
        axi_write('h10, 0);
        axi_write('h00, 1);
        repeat (3) begin
            @(negedge axis_clk);
            check("len0 ss_tready", 32'(ss_tready), 0);
            check("len0 sm_tvalid", 32'(sm_tvalid), 0);
        end
        axi_read('h00, d); check("len0 ctrl", d, 6);

        // config writes while busy are ignored; early ss_tlast flags tlast_err
        for (int k = 0; k < 16; k++) tap_m[k] = int'($urandom_range(0, 60)) - 30;
        for (int i = 0; i < 3; i++) samp[i] = int'($urandom_range(0, 60)) - 30;
        setup_frame(4, 3);
        axi_write('h20, 32'hDEAD);
        axi_write('h14, 2);
        axi_read('h20, d); check("busy tap0 read", d, tap_m[0]);
        axi_read('h14, d); check("busy tap_num read", d, 4);
        axi_read('h00, d); check("busy ctrl", d, 0);
        drive_frame(3, 1);
        finish_frame(1);
        axi_read('h00, d); check("tlast_err sticky", d, 12);

        // tap_num clamping
        axi_write('h14, 0);  axi_read('h14, d); check("tap_num clamp low", d, 1);
        axi_write('h14, 40); axi_read('h14, d); check("tap_num clamp high", d, 16);

        // random frames under random backpressure
        bp_en = 1;
        for (int f = 0; f < 4; f++) begin
            int tn_raw = int'($urandom_range(0, 20));
            int len = int'($urandom_range(1, 12));
            for (int k = 0; k < 16; k++) tap_m[k] = int'($urandom);
            for (int i = 0; i < len; i++) samp[i] = int'($urandom);
            setup_frame(tn_raw, len);
            drive_frame(len, len);
            finish_frame(0);
        end
        bp_en = 0;

        // reset after output 4 of 10, then a clean rerun
        load_gold();
        for (int i = 0; i < 10; i++) samp[i] = int'($urandom_range(0, 100)) - 50;
        setup_frame(11, 10);
        fork
            drive_frame(10, 10);
            begin
                int t = 0;
                while (frame_out < 4 && t < 3000) begin @(negedge axis_clk); t++; end
                if (frame_out < 4) timeout_fail("fourth output");
                @(posedge axis_clk); #1;
                axis_rst = 1; abort = 1;
            end
        join
        @(negedge axis_clk);
        check_quiet("mid reset");
        exp_q.delete(); last_q.delete();
        repeat (2) @(posedge axis_clk);
        #1 axis_rst = 0; abort = 0;
        axi_read('h00, d); check("ctrl after mid reset", d, 4);
        axi_read('h20, d); check("tap0 after mid reset", d, 0);
        for (int i = 0; i < 11; i++) samp[i] = (i == 0) ? 1 : 0;
        setup_frame(11, 11);
        drive_frame(11, 11);
        finish_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
